alu_instr_encoder: RTL

- Inverse of the ALU control decode: takes ALU operation requests (3-bit ALU select plus register fields) and builds the matching 32-bit MIPS R-type instruction words.
- Encoded words are buffered in a small FIFO and emitted over a valid/ready stream.
- Feeds instruction memory preload and the datapath testbench, so every word it emits decodes back to the requested ALU select.

---
 rtl/alu_enc_pkg.sv | 34 +++
 rtl/instr_fifo.sv | 71 +++++++
 rtl/alu_instr_encoder.sv | 79 +++++++
 3 files changed

// File: rtl/alu_enc_pkg.sv
// Shared constants and the select-to-funct mapping for the R-type encoder.
package alu_enc_pkg;

    localparam logic [5:0] OPC_RTYPE   = 6'b000000;
    localparam logic [4:0] SHAMT_ZERO  = 5'b00000;

    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;

    // No funct decodes back to this select.
    localparam logic [2:0] SEL_ILLEGAL = 3'b011;

    // Returns {legal, funct}; funct is zero for the illegal select.
    function automatic logic [6:0] sel_to_funct(input logic [2:0] sel);
        logic [6:0] r;
        case (sel)
            3'b000:  r = {1'b1, FUNCT_AND};
            3'b001:  r = {1'b1, FUNCT_OR};
            3'b010:  r = {1'b1, FUNCT_ADD};
            3'b100:  r = {1'b1, FUNCT_SUB};
            3'b101:  r = {1'b1, FUNCT_SRL};
            3'b110:  r = {1'b1, FUNCT_XOR};
            3'b111:  r = {1'b1, FUNCT_NOR};
            default: r = 7'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered occupancy; head word is always visible on pop_data.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full     = (cnt_q == LW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign level    = cnt_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Guard against overflow/underflow regardless of what the caller does.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state: write slot, pointer advance (DEPTH is a power of two so pointers wrap naturally), occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; storage is cleared too so the head reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_instr_encoder.sv
// Turns ALU select + register fields into MIPS R-type words, buffers them, and counts illegal selects.
module alu_instr_encoder
    import alu_enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_sel,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic                     err_pulse,
    output logic [ERR_W-1:0]         err_count,
    output logic [$clog2(DEPTH):0]   level
);

    logic [6:0]       dec;
    logic             legal;
    logic [5:0]       funct;
    logic [31:0]      word;
    logic             accept, push, pop, full, empty;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    assign dec    = sel_to_funct(in_sel);
    assign legal  = dec[6];
    assign funct  = dec[5:0];
    assign word   = {OPC_RTYPE, in_rs, in_rt, in_rd, SHAMT_ZERO, funct};

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign accept    = in_valid & in_ready;
    assign push      = accept & legal;
    assign pop       = out_valid & out_ready;

    instr_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .pop_data  (out_instr),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // An accepted illegal select is consumed without a push; flag it and bump the saturating count.
    always_comb begin
        err_pulse_d = accept & ~legal;
        err_count_d = err_count_q;
        if (err_pulse_d && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    // Error state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule
